vga_capture: RTL

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA sync timing and decimates the active picture 8:1 per axis into
// 80x60 video-memory writes. Optional frame counter enabled by VGA_CAPTURE_FRAME_COUNT_EN.
module vga_capture #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_PW    = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned V_TOTAL = 521,
    parameter int unsigned V_PW    = 2,
    parameter int unsigned V_BP    = 29,
    parameter int unsigned V_DISP  = 480
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iHsync,
    input  logic        iVsync,
    input  logic [2:0]  iRGB,
    output logic        oWriteEnable,
    output logic [12:0] oWriteAddress,
    output logic [2:0]  oDataOut,
    output logic        oLocked,
    output logic [7:0]  oFrameCount
);

    localparam logic [9:0] HMax     = 10'd1023;
    localparam logic [9:0] HNearMax = 10'd1022;
    localparam logic [9:0] VMax     = 10'd1023;
    localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
    localparam logic [9:0] HStart   = 10'(H_PW + H_BP);
    localparam logic [9:0] HEnd     = 10'(H_PW + H_BP + H_DISP);
    localparam logic [9:0] VStart   = 10'(V_PW + V_BP);
    localparam logic [9:0] VEnd     = 10'(V_PW + V_BP + V_DISP);

    typedef enum logic [1:0] {
        StUnlocked,
        StAcquire,
        StLocked
    } state_e;

    logic        r_hs_s1, r_hs_s2, r_hs_s3;
    logic        r_vs_s1, r_vs_s2, r_vs_s3;
    logic [2:0]  r_rgb_s1, r_rgb_s2;
    logic [9:0]  r_hcnt, r_vcnt;
    logic        r_v_pend, r_h_seen, r_v_seen;
    state_e      r_state;
    logic        r_good;
    logic        r_we;
    logic [12:0] r_addr;
    logic [2:0]  r_data;

    logic        w_hs_fall, w_vs_fall, w_frame_end;
    logic [9:0]  w_hcnt_nxt, w_vcnt_nxt;
    logic        w_line_err, w_frame_err, w_err;
    state_e      w_state_nxt;
    logic        w_good_nxt;
    logic [9:0]  w_x;
    logic [8:0]  w_y;
    logic        w_h_act, w_v_act, w_wr;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_hs_s1  <= 1'b1;
            r_hs_s2  <= 1'b1;
            r_hs_s3  <= 1'b1;
            r_vs_s1  <= 1'b1;
            r_vs_s2  <= 1'b1;
            r_vs_s3  <= 1'b1;
            r_rgb_s1 <= '0;
            r_rgb_s2 <= '0;
        end else begin
            r_hs_s1  <= iHsync;
            r_hs_s2  <= r_hs_s1;
            r_hs_s3  <= r_hs_s2;
            r_vs_s1  <= iVsync;
            r_vs_s2  <= r_vs_s1;
            r_vs_s3  <= r_vs_s2;
            r_rgb_s1 <= iRGB;
            r_rgb_s2 <= r_rgb_s1;
        end
    end

    // A frame ends on the first hsync fall at or after a vsync fall.
    always_comb begin
        w_hs_fall   = r_hs_s3 & ~r_hs_s2;
        w_vs_fall   = r_vs_s3 & ~r_vs_s2;
        w_frame_end = w_hs_fall & (r_v_pend | w_vs_fall);

        if (w_hs_fall) begin
            w_hcnt_nxt = '0;
        end else if (r_hcnt == HMax) begin
            w_hcnt_nxt = HMax;
        end else begin
            w_hcnt_nxt = r_hcnt + 10'd1;
        end

        w_vcnt_nxt = r_vcnt;
        if (w_frame_end) begin
            w_vcnt_nxt = '0;
        end else if (w_hs_fall && (r_vcnt != VMax)) begin
            w_vcnt_nxt = r_vcnt + 10'd1;
        end

        w_line_err  = (w_hs_fall & r_h_seen & (r_hcnt != HLast)) |
                      (~w_hs_fall & (r_hcnt >= HNearMax));
        w_frame_err = (w_frame_end & r_v_seen & (r_vcnt != VLast)) |
                      (w_hs_fall & ~w_frame_end & (r_vcnt >= VLast));
        w_err       = w_line_err | w_frame_err;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_v_pend <= 1'b0;
            r_h_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
            if (w_frame_end) begin
                r_v_pend <= 1'b0;
            end else if (w_vs_fall) begin
                r_v_pend <= 1'b1;
            end
            if (w_hs_fall) begin
                r_h_seen <= 1'b1;
            end
            if (w_frame_end) begin
                r_v_seen <= 1'b1;
            end
        end
    end

    // Any timing error drops lock immediately; r_good remembers one clean frame.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            StUnlocked: begin
                w_good_nxt = 1'b0;
                if (w_vs_fall) begin
                    w_state_nxt = StAcquire;
                end
            end
            StAcquire: begin
                if (w_err) begin
                    w_state_nxt = StUnlocked;
                    w_good_nxt  = 1'b0;
                end else if (w_frame_end && r_v_seen) begin
                    if (r_good) begin
                        w_state_nxt = StLocked;
                        w_good_nxt  = 1'b0;
                    end else begin
                        w_good_nxt = 1'b1;
                    end
                end
            end
            StLocked: begin
                if (w_err) begin
                    w_state_nxt = StUnlocked;
                end
            end
            default: begin
                w_state_nxt = StUnlocked;
                w_good_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= StUnlocked;
            r_good  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    // Pixel position tracks the second synchroniser stage, giving three cycles to the strobe.
    always_comb begin
        w_x     = w_hcnt_nxt - HStart;
        w_y     = 9'(r_vcnt - VStart);
        w_h_act = (w_hcnt_nxt >= HStart) && (w_hcnt_nxt < HEnd);
        w_v_act = (r_vcnt >= VStart) && (r_vcnt < VEnd);
        w_wr    = (r_state == StLocked) && !w_err && w_h_act && w_v_act &&
                  (w_x[2:0] == 3'd0) && (w_y[2:0] == 3'd0);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_addr <= {w_x[9:3], w_y[8:3]};
                r_data <= r_rgb_s2;
            end
        end
    end

`ifdef VGA_CAPTURE_FRAME_COUNT_EN
    logic [7:0] r_frame_cnt;
    logic       r_full_frame;

    // r_full_frame marks a frame that began while already LOCKED.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_frame_cnt  <= '0;
            r_full_frame <= 1'b0;
        end else begin
            if (w_frame_end && !w_err && (r_state == StLocked) && r_full_frame) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_state_nxt != StLocked) begin
                r_full_frame <= 1'b0;
            end else if (w_frame_end) begin
                r_full_frame <= 1'b1;
            end
        end
    end

    assign oFrameCount = r_frame_cnt;
`else
    assign oFrameCount = 8'd0;
`endif

    assign oWriteEnable  = r_we;
    assign oWriteAddress = r_addr;
    assign oDataOut      = r_data;
    assign oLocked       = (r_state == StLocked);

endmodule
